// File: rtl/conv_encoder_k7r3_if.sv
// Stream interface for the K=7 rate-1/3 convolutional encoder.
// The encoder is the slave. The environment that feeds bits and consumes codewords
// is the master.
interface conv_encoder_k7r3_if;
    logic       start_in;
    logic       bit_in;
    logic       bit_valid_in;
    logic       bit_ready_out;
    logic [3:0] yn_out0;
    logic [3:0] yn_out1;
    logic [3:0] yn_out2;
    logic       sym_valid_out;
    logic       sym_ready_in;
    logic       sym_last_out;
    logic       busy_out;

    modport master (
        output start_in, bit_in, bit_valid_in, sym_ready_in,
        input  bit_ready_out, yn_out0, yn_out1, yn_out2,
               sym_valid_out, sym_last_out, busy_out
    );

    modport slave (
        input  start_in, bit_in, bit_valid_in, sym_ready_in,
        output bit_ready_out, yn_out0, yn_out1, yn_out2,
               sym_valid_out, sym_last_out, busy_out
    );
endinterface

// File: rtl/conv_encoder_k7r3.sv
// Rate-1/3, K=7 convolutional encoder.
// A frame of FRAME_LEN info bits is followed by K-1 zero tail bits, so the trellis
// ends in state 0. Each bit produces one 3-symbol codeword. In each symbol, 4'b0000
// means a coded 0 and 4'b1111 means a coded 1.
module conv_encoder_k7r3 #(
    parameter int             K         = 7,
    parameter logic [K-1:0]   G0        = 7'o133,
    parameter logic [K-1:0]   G1        = 7'o171,
    parameter logic [K-1:0]   G2        = 7'o165,
    parameter int             FRAME_LEN = 64
) (
    input  logic               clk,
    input  logic               reset,
    conv_encoder_k7r3_if.slave bus
);
    localparam int CW = $clog2(FRAME_LEN + K);

    typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;

    state_t        state;
    logic [K-2:0]  sr;
    logic [CW-1:0] cnt;
    logic          out_free;
    logic          load;
    logic          u;
    logic [K-1:0]  word;

    // Pick the next encoder input bit. Decide whether the output register loads this cycle.
    always_comb begin
        out_free = !bus.sym_valid_out || bus.sym_ready_in;
        u        = 1'b0;
        load     = 1'b0;
        case (state)
            DATA: begin
                u    = bus.bit_in;
                load = bus.bit_valid_in && out_free;
            end
            TAIL: begin
                load = out_free;
            end
            default: begin
                u    = 1'b0;
                load = 1'b0;
            end
        endcase
        word = {u, sr};
    end

    assign bus.bit_ready_out = (state == DATA) && out_free;
    assign bus.busy_out      = (state != IDLE);

    // Frame FSM, shift register and the single-stage output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            sr                <= '0;
            cnt               <= '0;
            bus.yn_out0       <= '0;
            bus.yn_out1       <= '0;
            bus.yn_out2       <= '0;
            bus.sym_valid_out <= 1'b0;
            bus.sym_last_out  <= 1'b0;
        end else begin
            if (load) begin
                bus.yn_out0       <= {4{^(G0 & word)}};
                bus.yn_out1       <= {4{^(G1 & word)}};
                bus.yn_out2       <= {4{^(G2 & word)}};
                bus.sym_valid_out <= 1'b1;
                bus.sym_last_out  <= (state == TAIL) && (cnt == CW'(K - 2));
                sr                <= word[K-1:1];
            end else if (bus.sym_ready_in) begin
                bus.sym_valid_out <= 1'b0;
                bus.sym_last_out  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.start_in) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    if (load) begin
                        if (cnt == CW'(FRAME_LEN - 1)) begin
                            state <= TAIL;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                TAIL: begin
                    if (load) begin
                        if (cnt == CW'(K - 2)) begin
                            state <= DRAIN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (bus.sym_valid_out && bus.sym_ready_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
